// File: rtl/i2c_slave.sv
//==============================================================================
// Module      : i2c_slave
// Description : Oversampled I2C target with a byte-addressed register file.
//               Pointer-then-data protocol, 7-bit address, open-drain SDA,
//               no clock stretching.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module i2c_slave #(
    parameter logic [6:0] I2C_ADDR = 7'h10,
    parameter int         DEPTH    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic scl,
    inout  wire  sda
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RACK      = 4'd8;
    localparam logic [3:0] S_WAIT      = 4'd9;

    // Synchronizer chains plus one extra stage for edge detection
    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;

    logic [3:0]    state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [7:0]    sh_q,    sh_d;
    logic          oe_q,    oe_d;
    logic          rw_q,    rw_d;
    logic [PW-1:0] ptr_q,   ptr_d;
    logic [7:0]    mem_q [DEPTH];

    logic          scl_rise, scl_fall, bus_start, bus_stop;
    logic          mem_we;
    logic [7:0]    byte_in;
    logic [7:0]    rd_byte;

    // Open-drain: only ever pull low or release
    assign sda = oe_q ? 1'b0 : 1'bz;

    // Bring SCL/SDA into the clk domain; idle bus level is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= scl;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    assign scl_rise  =  scl_s2_q & ~scl_prev_q;
    assign scl_fall  = ~scl_s2_q &  scl_prev_q;
    assign bus_start =  scl_s2_q &  scl_prev_q &  sda_prev_q & ~sda_s2_q;
    assign bus_stop  =  scl_s2_q &  scl_prev_q & ~sda_prev_q &  sda_s2_q;

    // Incoming byte as it will look once the current bit is shifted in
    assign byte_in = {sh_q[6:0], sda_s2_q};
    assign rd_byte = mem_q[ptr_q];

    // Protocol FSM next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        oe_d    = oe_q;
        rw_d    = rw_q;
        ptr_d   = ptr_q;
        mem_we  = 1'b0;
        if (bus_stop) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
        end else if (bus_start) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (byte_in[7:1] == I2C_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = S_WAIT;
                            end
                        end
                    end
                end
                // ACK phases: first fall asserts, second fall releases
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            cnt_d = 4'd0;
                            if (rw_q) begin
                                sh_d    = rd_byte;
                                oe_d    = ~rd_byte[7];
                                state_d = S_RDATA;
                            end else begin
                                oe_d    = 1'b0;
                                state_d = S_PTR;
                            end
                        end
                    end
                end
                S_PTR: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d   = byte_in[PW-1:0];
                            state_d = S_PTR_ACK;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!oe_q) begin
                            oe_d = 1'b1;
                        end else begin
                            oe_d    = 1'b0;
                            cnt_d   = 4'd0;
                            state_d = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (scl_rise) begin
                        sh_d  = byte_in;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            mem_we  = 1'b1;
                            ptr_d   = ptr_q + PW'(1);
                            state_d = S_WDATA_ACK;
                        end
                    end
                end
                // Bit 7 was presented on entry; each later fall presents the next bit
                S_RDATA: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            ptr_d   = ptr_q + PW'(1);
                            state_d = S_RACK;
                        end
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        sh_d = {sh_q[6:0], sh_q[7]};
                        oe_d = ~sh_q[6];
                    end
                end
                // cnt 8: release for master ACK bit; cnt 9: master ACKed, reload
                S_RACK: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            oe_d = 1'b0;
                        end else begin
                            sh_d    = rd_byte;
                            oe_d    = ~rd_byte[7];
                            cnt_d   = 4'd0;
                            state_d = S_RDATA;
                        end
                    end else if (scl_rise && cnt_q == 4'd8) begin
                        if (sda_s2_q) begin
                            state_d = S_WAIT;
                        end else begin
                            cnt_d = 4'd9;
                        end
                    end
                end
                S_IDLE, S_WAIT: begin
                    oe_d = 1'b0;
                end
                default: begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    // FSM, shifter and pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            sh_q    <= 8'h00;
            oe_q    <= 1'b0;
            rw_q    <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            oe_q    <= oe_d;
            rw_q    <= rw_d;
            ptr_q   <= ptr_d;
        end
    end

    // Register file, written on the 8th SCL rise of a data byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_in;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
//==============================================================================
// Module      : tb_i2c_slave
// Description : Directed bench for i2c_slave with a bit-banged I2C master.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_i2c_slave;

    localparam int T = 50;   // quarter SCL period (SCL = 20 clk)

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl   = 1'b1;
    logic m_low = 1'b0;
    wire  sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave #(.I2C_ADDR(7'h10), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .scl (scl),
        .sda (sda)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #T;
        scl   = 1'b1; #T;
        m_low = 1'b1; #T;
        scl   = 1'b0; #T;
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #T;
        scl   = 1'b1; #T;
        m_low = 1'b0; #T;
    endtask

    task automatic i2c_wr(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            m_low = ~b[i]; #T;
            scl   = 1'b1;  #(2*T);
            scl   = 1'b0;  #T;
        end
        m_low = 1'b0; #T;
        scl   = 1'b1; #T;
        ack   = (sda == 1'b0); #T;
        scl   = 1'b0; #T;
    endtask

    task automatic i2c_rd(input logic nack, output logic [7:0] b);
        m_low = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            #T;
            scl  = 1'b1; #T;
            b[i] = sda;  #T;
            scl  = 1'b0; #T;
        end
        m_low = ~nack; #T;
        scl   = 1'b1;  #(2*T);
        scl   = 1'b0;  #T;
        m_low = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [7:0] b, input logic exp_ack);
        logic a;
        i2c_wr(b, a);
        chk(tag, {7'd0, a}, {7'd0, exp_ack});
    endtask

    task automatic rd_chk(input string tag, input logic nack, input logic [7:0] exp);
        logic [7:0] d;
        i2c_rd(nack, d);
        chk(tag, d, exp);
    endtask

    initial begin
        // Reset then idle
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #(4*T);
        chk("idle_sda", {7'd0, sda}, 8'h01);

        i2c_start();
        wr_chk("r0_addr", 8'h20, 1'b1);
        wr_chk("r0_ptr",  8'h00, 1'b1);
        i2c_start();
        wr_chk("r0_raddr", 8'h21, 1'b1);
        rd_chk("r0_reg0", 1'b0, 8'h00);
        rd_chk("r0_reg1", 1'b0, 8'h00);
        rd_chk("r0_reg2", 1'b0, 8'h00);
        rd_chk("r0_reg3", 1'b1, 8'h00);
        i2c_stop();

        // Preload reg4 so the pointer position after the burst is observable
        i2c_start();
        wr_chk("pre_addr", 8'h20, 1'b1);
        wr_chk("pre_ptr",  8'h04, 1'b1);
        wr_chk("pre_d",    8'h3C, 1'b1);
        i2c_stop();

        // Write burst
        i2c_start();
        wr_chk("wb_addr", 8'h20, 1'b1);
        wr_chk("wb_ptr",  8'h02, 1'b1);
        wr_chk("wb_d0",   8'hA5, 1'b1);
        wr_chk("wb_d1",   8'h5A, 1'b1);
        i2c_stop();

        // Read from current pointer: must be reg4
        i2c_start();
        wr_chk("cur_addr", 8'h21, 1'b1);
        rd_chk("cur_ptr4", 1'b1, 8'h3C);
        i2c_stop();

        // Random read
        i2c_start();
        wr_chk("rr_addr", 8'h20, 1'b1);
        wr_chk("rr_ptr",  8'h02, 1'b1);
        i2c_start();
        wr_chk("rr_raddr", 8'h21, 1'b1);
        rd_chk("rr_reg2", 1'b0, 8'hA5);
        rd_chk("rr_reg3", 1'b1, 8'h5A);
        #T;
        chk("rr_nack_rel", {7'd0, sda}, 8'h01);
        i2c_stop();

        // Address mismatch
        i2c_start();
        wr_chk("mm_addr", 8'h22, 1'b0);
        wr_chk("mm_data", 8'hFF, 1'b0);
        i2c_stop();
        i2c_start();
        wr_chk("mm_chk_addr", 8'h20, 1'b1);
        wr_chk("mm_chk_ptr",  8'h02, 1'b1);
        i2c_start();
        wr_chk("mm_chk_raddr", 8'h21, 1'b1);
        rd_chk("mm_reg2", 1'b0, 8'hA5);
        rd_chk("mm_reg3", 1'b1, 8'h5A);
        i2c_stop();

        // Pointer wrap
        i2c_start();
        wr_chk("wr_addr", 8'h20, 1'b1);
        wr_chk("wr_ptr",  8'h0F, 1'b1);
        wr_chk("wr_d15",  8'h11, 1'b1);
        wr_chk("wr_d0",   8'h22, 1'b1);
        i2c_stop();
        i2c_start();
        wr_chk("wrr_addr", 8'h20, 1'b1);
        wr_chk("wrr_ptr",  8'h0F, 1'b1);
        i2c_start();
        wr_chk("wrr_raddr", 8'h21, 1'b1);
        rd_chk("wrr_reg15", 1'b0, 8'h11);
        rd_chk("wrr_reg0",  1'b1, 8'h22);
        i2c_stop();

        // Reset mid-read while the slave drives bit 7 (0) of reg15 = 0x11
        i2c_start();
        wr_chk("rm_addr", 8'h20, 1'b1);
        wr_chk("rm_ptr",  8'h0F, 1'b1);
        i2c_start();
        wr_chk("rm_raddr", 8'h21, 1'b1);
        #T;
        scl = 1'b1; #T;
        chk("rm_drv0", {7'd0, sda}, 8'h00);
        #3 rst = 1'b1;
        #1;
        chk("rm_rst_rel", {7'd0, sda}, 8'h01);
        repeat (5) @(posedge clk);
        #2 rst = 1'b0;
        #(2*T);
        i2c_start();
        wr_chk("rm_post_addr", 8'h21, 1'b1);
        rd_chk("rm_post_reg0", 1'b1, 8'h00);
        i2c_stop();

        #(4*T);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_slave.md
# i2c_slave

Synthesizable I2C slave with a small byte-addressed register file, used as the I2C target on the video I2C bus (IIC_SDA_VIDEO / IIC_SCL_VIDEO) in the board-level integration bench and design. It oversamples SCL/SDA with the system clock. It decodes START, STOP and repeated START, and ACKs its own 7-bit address. Masters use the standard pointer-then-data protocol to write and read its registers.

## Interface
- `I2C_ADDR`, default 7'h10: 7-bit slave address.
- `DEPTH`, default 16: number of 8-bit registers (power of two); the pointer is log2(DEPTH) bits.
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `scl`, input, 1: I2C clock from the master. The bus has an external pull-up; this block never drives SCL (no clock stretching).
- `sda`, inout, 1: I2C data, open-drain. The block drives 1'b0 or 1'bz only; the bus has an external pull-up.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer into the clk domain. A registered copy of the synchronized value gives edge detection.
- Bus conditions, all detected while synchronized SCL is high:
  - START: SDA falls.
  - STOP: SDA rises.
  - Repeated START is a START seen in any non-IDLE state.
- States:
  - IDLE: SDA released.
  - ADDR: shift 8 bits, MSB first, one per SCL rise.
  - ADDR_ACK.
  - PTR: receive the pointer byte.
  - PTR_ACK.
  - WDATA: receive a data byte.
  - WDATA_ACK.
  - RDATA: drive a byte, MSB first.
  - RACK: sample the master's ACK/NACK.
  - WAIT: released, waiting for STOP or START.
- Transitions:
  - START from any state goes to ADDR and clears the bit counter.
  - STOP from any state goes to IDLE and releases SDA.
  - ADDR, after 8 bits:
    - If addr[7:1] != I2C_ADDR, go to WAIT and do not ACK.
    - On a match, go to ADDR_ACK. The R/W bit (bit 0) selects the next data phase: 0 = write, 1 = read.
  - Write, first byte after the address: go to PTR, load the pointer, then PTR_ACK.
  - Write, later bytes: go to WDATA, write mem[ptr] <= byte, ptr <= ptr+1, then WDATA_ACK.
  - Read: go to RDATA and shift out mem[ptr]. After the 8th bit, go to RACK and set ptr <= ptr+1.
  - RACK, master ACK (SDA low at SCL rise): load mem[ptr] and go back to RDATA.
  - RACK, master NACK: go to WAIT.
- ACK phases: pull SDA low from the SCL fall after the 8th bit until the SCL fall after the 9th bit, then release.
- The pointer wraps modulo DEPTH for reads and writes, e.g. writing at 15 then 16 writes reg 15 then reg 0.
- The pointer persists across transactions. A read issued without a preceding pointer write starts at the current pointer.
- Writing only the pointer byte, then a repeated START and a read, reads from that pointer. This is the standard register-read sequence.

## Timing
- Reset forces:
  - State = IDLE.
  - SDA released (z).
  - ptr = 0.
  - All registers = 8'h00.
  - Synchronizers = 1.
- Reset mid-transfer releases SDA immediately (asynchronous) and aborts the transfer.
- Input latency: an SCL/SDA edge is acted on 3 clk after it reaches the pins (2 sync + 1 edge-detect).
- SDA drive changes (ACK assert/release, read bits) occur only on detected SCL falls, 3 clk after the pin edge. Never change SDA while SCL is high, other than the release caused by reset.
- Data is sampled on the detected SCL rise.
- Requirement: clk ≥ 16× SCL frequency. At 100 MHz this supports 100 kHz and 400 kHz masters.
- A register write takes effect on the clk that detects the 8th SCL rise of the data byte. That data is readable in the same transaction after a repeated START.

## Test plan
- Reset then idle:
  - Hold rst 10 clk and release with SCL=SDA=1.
  - Required: SDA z; a read of regs 0..3 after a pointer write of 0 returns 00,00,00,00.
- Write burst:
  - Send START, 0x20 (addr 0x10, W), 0x02, 0xA5, 0x5A, STOP.
  - Required: ACK on all 4 bytes; reg2=A5, reg3=5A; ptr=4.
- Random read:
  - Send START, 0x20, 0x02, repeated START, 0x21, read 2 bytes (ACK then NACK), STOP.
  - Required: data A5 then 5A; SDA released after the NACK.
- Address mismatch:
  - Send START, 0x22 (addr 0x11), 0xFF, STOP.
  - Required: no ACK (SDA stays high at the 9th bit); registers unchanged.
- Pointer wrap:
  - Send START, 0x20, 0x0F, 0x11, 0x22, STOP, then a read from ptr 0x0F.
  - Required: reg15=11, reg0=22; the read returns 11, 22.
- Reset mid-read:
  - Assert rst while the slave drives a 0 data bit.
  - Required: SDA goes z within the same clk; the next START, 0x21 read returns 00.
